// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pipe_pkg
// Description : Shared definitions for the pipelined RISC-V core's pipeline
//               registers: default field widths, the bubble instruction, the
//               IF/ID entry layout and the skid-buffer occupancy encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

  localparam int unsigned PIPE_PC_W   = 64;
  localparam int unsigned PIPE_INST_W = 32;

  // addi x0, x0, 0 -- architecturally harmless if decode ignores valid
  localparam logic [31:0] PIPE_NOP_INST = 32'h0000_0013;

  // IF/ID entry at the default widths. Parametrised users build an
  // equivalent struct locally with the same field order {pc, inst}.
  typedef struct packed {
    logic [PIPE_PC_W-1:0]   pc;
    logic [PIPE_INST_W-1:0] inst;
  } if_id_entry_t;

  // Occupancy encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b11
  } skid_state_e;

endpackage : riscv_pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : Generic WIDTH-bit valid/ready skid buffer. A main entry drives
//               the output; a one-entry skid absorbs the word accepted in the
//               cycle the consumer stalls, so the producer-side ready can be a
//               pure register with no path from out_ready_i.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               clear_i             - drop all held and incoming entries
//               in_valid_i/_ready_o - producer handshake (ready registered)
//               in_data_i           - producer payload
//               out_valid_o/_ready_i- consumer handshake
//               out_data_o          - consumer payload (zero after clear/reset)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             in_ready_q,   in_ready_d;

  logic        accept;
  logic        consume;
  skid_state_e state;

  assign accept  = in_valid_i & in_ready_q;
  assign consume = main_valid_q & out_ready_i;
  assign state   = skid_state_e'({skid_valid_q, main_valid_q});

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    if (clear_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = '0;
      skid_data_d  = '0;
    end else begin
      unique case (state)
        SKID_EMPTY: begin
          if (accept) begin
            main_data_d  = in_data_i;
            main_valid_d = 1'b1;
          end
        end
        SKID_ONE: begin
          if (accept && consume) begin
            main_data_d = in_data_i;
          end else if (accept) begin
            skid_data_d  = in_data_i;
            skid_valid_d = 1'b1;
          end else if (consume) begin
            main_valid_d = 1'b0;
          end
        end
        SKID_FULL: begin
          // in_ready is low here, so no accept can coincide with the move
          if (consume) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: fall back to empty rather than lock up
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end

    // Ready for next cycle follows the skid slot we are about to hold
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // A skid entry without a main entry would reorder the stream
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(skid_valid_q && !main_valid_q));
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

endmodule : pipe_skid_buf
`default_nettype wire

// File: rtl/if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_pipe_reg
// Description : IF/ID pipeline register with valid/ready handshaking, a
//               one-entry skid buffer for decode back-pressure, a flush for
//               taken branches/jumps, and NOP substitution while empty.
//               Optional performance counters under IF_ID_PERF_CNT_EN.
// Ports       : clk, reset              - clock, synchronous active-high reset
//               flush                   - discard held and incoming entries
//               in_valid/in_ready       - fetch handshake (in_ready registered)
//               in_pc/in_inst           - fetched PC and instruction
//               out_valid/out_ready     - decode handshake
//               out_pc/out_inst         - to decode (0 / NOP_INST when empty)
//               stall_cnt/flush_cnt     - [IF_ID_PERF_CNT_EN only] counters
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_pipe_reg
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned        PC_W     = PIPE_PC_W,
  parameter int unsigned        INST_W   = PIPE_INST_W,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(PIPE_NOP_INST)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  // Same layout as if_id_entry_t, sized by this instance's parameters
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t in_entry;
  entry_t out_entry;
  logic   buf_valid;

  assign in_entry.pc   = in_pc;
  assign in_entry.inst = in_inst;

  pipe_skid_buf #(
    .WIDTH (PC_W + INST_W)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_entry),
    .out_valid_o (buf_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_entry)
  );

  // Decode may execute regardless of out_valid, so an empty stage must
  // present a bubble rather than stale data.
  assign out_valid = buf_valid;
  assign out_pc    = buf_valid ? out_entry.pc   : '0;
  assign out_inst  = buf_valid ? out_entry.inst : NOP_INST;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Any entry valid reduces to the main valid: skid never holds alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (buf_valid && !out_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush && buf_valid) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Flush deliberately does not clear the counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule : if_id_pipe_reg
`default_nettype wire

// File: tb/tb_if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_pipe_reg
// Description : Self-checking bench for if_id_pipe_reg: directed handshake,
//               back-pressure, flush and reset sequences, a randomised
//               stream against a queue model, and (with IF_ID_PERF_CNT_EN)
//               the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_pipe_reg;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned INST_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       flush_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  if_id_pipe_reg dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction tied to its PC so misrouted inst fields are visible
  function automatic logic [31:0] mk_inst(input logic [63:0] pc);
    return 32'h00A0_0000 ^ pc[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [63:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_inst  = mk_inst(pc);
  endtask

  // Model state for the random stream
  logic [63:0] q_pc[$];
  logic [63:0] next_pc;
  logic        exp_ready;
  logic        acc, con;
  logic        ready_before;

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(1'b0, 64'h0);
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_pc",    out_pc,    0);
    chk("rst_inst",  out_inst,  NOP);
    chk("rst_ready", in_ready,  1);
    reset = 1'b0;

    // 1: streaming at full rate
    out_ready = 1'b1;
    offer(1'b1, 64'h0); tick();
    chk("t1_valid0", out_valid, 1);
    chk("t1_pc0",    out_pc,    64'h0);
    chk("t1_inst0",  out_inst,  mk_inst(64'h0));
    chk("t1_rdy0",   in_ready,  1);
    offer(1'b1, 64'h4); tick();
    chk("t1_pc4",    out_pc,    64'h4);
    chk("t1_rdy4",   in_ready,  1);
    offer(1'b1, 64'h8); tick();
    chk("t1_pc8",    out_pc,    64'h8);
    chk("t1_inst8",  out_inst,  mk_inst(64'h8));
    offer(1'b0, 64'h0); tick();
    chk("t1_drain",  out_valid, 0);
    chk("t1_nop",    out_inst,  NOP);

    // 2: back-pressure into the skid
    out_ready = 1'b0;
    offer(1'b1, 64'h10); tick();
    chk("t2_pc10",   out_pc,    64'h10);
    offer(1'b1, 64'h14); tick();
    chk("t2_full_rdy", in_ready, 0);
    chk("t2_hold1",  out_pc,    64'h10);
    offer(1'b1, 64'h18); tick();
    chk("t2_hold2",  out_pc,    64'h10);
    chk("t2_rdy_lo", in_ready,  0);
    out_ready = 1'b1; tick();
    chk("t2_pc14",   out_pc,    64'h14);
    chk("t2_rdy_hi", in_ready,  1);
    tick();
    chk("t2_pc18",   out_pc,    64'h18);
    chk("t2_inst18", out_inst,  mk_inst(64'h18));
    offer(1'b0, 64'h0); tick();
    chk("t2_empty",  out_valid, 0);

    // 3: flush from FULL drops held and incoming entries
    out_ready = 1'b0;
    offer(1'b1, 64'h30); tick();
    offer(1'b1, 64'h34); tick();
    chk("t3_full",   in_ready,  0);
    flush = 1'b1; offer(1'b1, 64'h20); tick();
    chk("t3_valid",  out_valid, 0);
    chk("t3_inst",   out_inst,  NOP);
    chk("t3_pc",     out_pc,    0);
    chk("t3_ready",  in_ready,  1);
    flush = 1'b0; offer(1'b0, 64'h0); out_ready = 1'b1; tick();
    chk("t3_no20",   out_valid, 0);

    // 4: reset from FULL
    out_ready = 1'b0;
    offer(1'b1, 64'h40); tick();
    offer(1'b1, 64'h44); tick();
    chk("t4_full",   in_ready,  0);
    reset = 1'b1; offer(1'b1, 64'h48); tick();
    chk("t4_valid",  out_valid, 0);
    chk("t4_pc",     out_pc,    0);
    chk("t4_inst",   out_inst,  NOP);
    chk("t4_ready",  in_ready,  1);
    reset = 1'b0; offer(1'b0, 64'h0); out_ready = 1'b1; tick();
    chk("t4_after",  out_valid, 0);

    // 5: random stream against a queue model
    q_pc.delete();
    next_pc = 64'h1000;
    for (int i = 0; i < 2000; i++) begin
      offer(($urandom_range(0, 3) != 0), next_pc);
      out_ready = ($urandom_range(0, 2) != 0);
      exp_ready = (q_pc.size() < 2);
      chk("r_ready", in_ready,  exp_ready);
      chk("r_valid", out_valid, (q_pc.size() > 0));
      if (q_pc.size() > 0) begin
        chk("r_pc",   out_pc,   q_pc[0]);
        chk("r_inst", out_inst, mk_inst(q_pc[0]));
      end else begin
        chk("r_nop",  out_inst, NOP);
      end
      // in_ready must not react to out_ready within the cycle
      ready_before = in_ready;
      out_ready = ~out_ready; #1;
      chk("r_comb", in_ready, ready_before);
      out_ready = ~out_ready; #1;
      acc = in_valid & exp_ready;
      con = out_ready & (q_pc.size() > 0);
      if (con) void'(q_pc.pop_front());
      if (acc) begin
        q_pc.push_back(next_pc);
        next_pc = next_pc + 64'h4;
      end
      tick();
    end

`ifdef IF_ID_PERF_CNT_EN
    // 6: counters
    reset = 1'b1; offer(1'b0, 64'h0); out_ready = 1'b0; tick();
    reset = 1'b0;
    chk("c_stall0", stall_cnt, 0);
    chk("c_flush0", flush_cnt, 0);
    offer(1'b1, 64'h50); tick();
    offer(1'b0, 64'h0);
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b1; flush = 1'b1; tick();
    flush = 1'b0; offer(1'b1, 64'h54); tick();
    offer(1'b0, 64'h0); flush = 1'b1; tick();
    flush = 1'b0; tick();
    chk("c_stall5", stall_cnt, 5);
    chk("c_flush2", flush_cnt, 2);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_if_id_pipe_reg
`default_nettype wire
